// File: rtl/vram_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : vram_write_arbiter
//  Description : Shares the single VideoRAM write port between two character
//                requesters (A, B) and an internal fill engine used for
//                screen clear and scroll-line blanking. Requesters are
//                round-robin arbitrated when both are valid; the fill engine
//                owns the port exclusively while it runs. Every write leaves
//                through one output register, so at most one write per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module vram_write_arbiter #(
    parameter int              AW        = 11,
    parameter int              DW        = 8,
    parameter logic [DW-1:0]   FILL_CHAR = 8'h20
) (
    input  logic            clk25,
    input  logic            rst,

    input  logic            a_valid,
    output logic            a_ready,
    input  logic [AW-1:0]   a_addr,
    input  logic [DW-1:0]   a_data,

    input  logic            b_valid,
    output logic            b_ready,
    input  logic [AW-1:0]   b_addr,
    input  logic [DW-1:0]   b_data,

    input  logic            clr_start,
    input  logic [AW-1:0]   clr_base,
    input  logic [AW:0]     clr_len,
    output logic            clr_busy,

    output logic            vwr,
    output logic [AW-1:0]   vwaddr,
    output logic [DW-1:0]   vwdata
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } state_t;

    localparam logic [AW:0] c_cnt_one = {{AW{1'b0}}, 1'b1};

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_ptr;
    logic [AW-1:0]   w_ptr_nxt;
    logic [AW:0]     r_cnt;
    logic [AW:0]     w_cnt_nxt;

    // Round-robin pointer: 0 = A preferred, 1 = B preferred.
    logic            r_rr_b;

    logic            w_busy;
    logic            w_start_ok;
    logic            w_a_ready;
    logic            w_b_ready;

    logic            r_vwr;
    logic [AW-1:0]   r_vwaddr;
    logic [DW-1:0]   r_vwdata;

    assign w_busy     = (r_state == S_FILL);
    // A zero-length start is dropped; starts during a fill are dropped too
    // because only the IDLE state looks at clr_start.
    assign w_start_ok = (r_state == S_IDLE) && clr_start && (clr_len != '0);

    // The preferred requester wins a tie; a lone requester always wins.
    // Both readies drop while the fill engine owns the port.
    assign w_a_ready  = !w_busy && a_valid && (!b_valid || !r_rr_b);
    assign w_b_ready  = !w_busy && b_valid && (!a_valid ||  r_rr_b);

    // Fill engine next-state: load on accepted start, then walk ptr/cnt.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = S_FILL;
                    w_ptr_nxt   = clr_base;
                    w_cnt_nxt   = clr_len;
                end
            end
            S_FILL: begin
                w_ptr_nxt = r_ptr + 1'b1;
                w_cnt_nxt = r_cnt - 1'b1;
                if (r_cnt == c_cnt_one) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Fill engine state, address pointer and remaining-cell counter.
    always_ff @(posedge clk25) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Round-robin pointer moves to the requester that was not granted.
    always_ff @(posedge clk25) begin
        if (rst) begin
            r_rr_b <= 1'b0;
        end else if (w_a_ready) begin
            r_rr_b <= 1'b1;
        end else if (w_b_ready) begin
            r_rr_b <= 1'b0;
        end
    end

    // Registered VideoRAM write port; address/data hold when idle.
    always_ff @(posedge clk25) begin
        if (rst) begin
            r_vwr    <= 1'b0;
            r_vwaddr <= '0;
            r_vwdata <= '0;
        end else if (w_busy) begin
            r_vwr    <= 1'b1;
            r_vwaddr <= r_ptr;
            r_vwdata <= FILL_CHAR;
        end else if (w_a_ready) begin
            r_vwr    <= 1'b1;
            r_vwaddr <= a_addr;
            r_vwdata <= a_data;
        end else if (w_b_ready) begin
            r_vwr    <= 1'b1;
            r_vwaddr <= b_addr;
            r_vwdata <= b_data;
        end else begin
            r_vwr    <= 1'b0;
        end
    end

    assign a_ready  = w_a_ready;
    assign b_ready  = w_b_ready;
    assign clr_busy = w_busy;
    assign vwr      = r_vwr;
    assign vwaddr   = r_vwaddr;
    assign vwdata   = r_vwdata;

endmodule
`default_nettype wire

// File: tb/tb_vram_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vram_write_arbiter
//  Description : Directed self-checking bench for vram_write_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_vram_write_arbiter;

    localparam int AW = 11;
    localparam int DW = 8;

    logic            clk25;
    logic            rst;
    logic            a_valid;
    logic            a_ready;
    logic [AW-1:0]   a_addr;
    logic [DW-1:0]   a_data;
    logic            b_valid;
    logic            b_ready;
    logic [AW-1:0]   b_addr;
    logic [DW-1:0]   b_data;
    logic            clr_start;
    logic [AW-1:0]   clr_base;
    logic [AW:0]     clr_len;
    logic            clr_busy;
    logic            vwr;
    logic [AW-1:0]   vwaddr;
    logic [DW-1:0]   vwdata;

    int n_tests;
    int n_fail;

    vram_write_arbiter #(
        .AW        (AW),
        .DW        (DW),
        .FILL_CHAR (8'h20)
    ) u_dut (
        .clk25     (clk25),
        .rst       (rst),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .clr_start (clr_start),
        .clr_base  (clr_base),
        .clr_len   (clr_len),
        .clr_busy  (clr_busy),
        .vwr       (vwr),
        .vwaddr    (vwaddr),
        .vwdata    (vwdata)
    );

    initial clk25 = 1'b0;
    always #5 clk25 = ~clk25;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk25);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int cnt;
        int k;
        logic [AW-1:0] last_addr;

        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        a_valid   = 1'b0;
        a_addr    = '0;
        a_data    = '0;
        b_valid   = 1'b0;
        b_addr    = '0;
        b_data    = '0;
        clr_start = 1'b0;
        clr_base  = '0;
        clr_len   = '0;

        // ---------------- reset state ----------------
        do_reset();
        check_eq("rst_vwr",    vwr,      0);
        check_eq("rst_vwaddr", vwaddr,   0);
        check_eq("rst_vwdata", vwdata,   0);
        check_eq("rst_busy",   clr_busy, 0);
        check_eq("rst_aready", a_ready,  0);

        // ---------------- A only ----------------
        a_valid = 1'b1; a_addr = 11'h005; a_data = 8'h41;
        #1;
        check_eq("aonly_aready", a_ready, 1);
        check_eq("aonly_bready", b_ready, 0);
        tick();
        a_valid = 1'b0;
        check_eq("aonly_vwr",    vwr,    1);
        check_eq("aonly_vwaddr", vwaddr, 11'h005);
        check_eq("aonly_vwdata", vwdata, 8'h41);
        tick();
        check_eq("aonly_idle_vwr",  vwr,    0);
        check_eq("aonly_hold_addr", vwaddr, 11'h005);

        // ---------------- contention: alternate A,B,A,B ----------------
        do_reset();
        a_valid = 1'b1; a_addr = 11'h100; a_data = 8'hA0;
        b_valid = 1'b1; b_addr = 11'h200; b_data = 8'hB0;
        for (int i = 0; i < 8; i++) begin
            #1;
            check_eq("cont_aready", a_ready, ((i % 2) == 0) ? 1 : 0);
            check_eq("cont_bready", b_ready, ((i % 2) == 1) ? 1 : 0);
            tick();
            check_eq("cont_vwr", vwr, 1);
            if ((i % 2) == 0) begin
                check_eq("cont_a_addr", vwaddr, 11'h100 + i / 2);
                check_eq("cont_a_data", vwdata, 8'hA0 + i / 2);
                a_addr = 11'h100 + i / 2 + 1;
                a_data = 8'hA0 + i / 2 + 1;
            end else begin
                check_eq("cont_b_addr", vwaddr, 11'h200 + i / 2);
                check_eq("cont_b_data", vwdata, 8'hB0 + i / 2);
                b_addr = 11'h200 + i / 2 + 1;
                b_data = 8'hB0 + i / 2 + 1;
            end
        end
        a_valid = 1'b0; b_valid = 1'b0;
        tick();
        check_eq("cont_end_vwr", vwr, 0);

        // ---------------- wrap fill ----------------
        clr_start = 1'b1; clr_base = 11'h7FE; clr_len = 12'd4;
        #1;
        check_eq("wrap_busy_pre", clr_busy, 0);
        tick();
        clr_start = 1'b0;
        check_eq("wrap_busy0", clr_busy, 1);
        check_eq("wrap_vwr0",  vwr,      0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("wrap_vwr",    vwr,      1);
            check_eq("wrap_vwaddr", vwaddr,   (11'h7FE + i) & 11'h7FF);
            check_eq("wrap_vwdata", vwdata,   8'h20);
            check_eq("wrap_busy",   clr_busy, (i < 3) ? 1 : 0);
        end
        tick();
        check_eq("wrap_done_vwr", vwr, 0);

        // ---------------- fill vs requester ----------------
        a_valid = 1'b1; a_addr = 11'h123; a_data = 8'h55;
        clr_start = 1'b1; clr_base = 11'h640; clr_len = 12'd80;
        #1;
        check_eq("fvr_aready0", a_ready, 1);
        tick();
        clr_start = 1'b0;
        a_addr = 11'h124; a_data = 8'h56;
        check_eq("fvr_a_vwr",    vwr,      1);
        check_eq("fvr_a_vwaddr", vwaddr,   11'h123);
        check_eq("fvr_a_vwdata", vwdata,   8'h55);
        check_eq("fvr_busy",     clr_busy, 1);
        check_eq("fvr_aready1",  a_ready,  0);
        for (int i = 0; i < 80; i++) begin
            tick();
            check_eq("fvr_fill_vwr",  vwr,     1);
            check_eq("fvr_fill_addr", vwaddr,  11'h640 + i);
            check_eq("fvr_fill_data", vwdata,  8'h20);
            check_eq("fvr_aready",    a_ready, (i == 79) ? 1 : 0);
        end
        tick();
        a_valid = 1'b0;
        check_eq("fvr_a2_vwr",    vwr,    1);
        check_eq("fvr_a2_vwaddr", vwaddr, 11'h124);
        check_eq("fvr_a2_vwdata", vwdata, 8'h56);
        tick();
        check_eq("fvr_end_vwr", vwr, 0);

        // ---------------- ignored starts ----------------
        clr_start = 1'b1; clr_base = 11'h005; clr_len = 12'd0;
        tick();
        clr_start = 1'b0;
        check_eq("len0_busy", clr_busy, 0);
        check_eq("len0_vwr",  vwr,      0);
        tick();
        check_eq("len0_vwr2", vwr, 0);

        clr_start = 1'b1; clr_base = 11'h010; clr_len = 12'd3;
        tick();
        check_eq("dbl_busy", clr_busy, 1);
        clr_start = 1'b1; clr_base = 11'h300; clr_len = 12'd10;
        tick();
        clr_start = 1'b0;
        check_eq("dbl_first_addr", vwaddr, 11'h010);
        cnt = (vwr === 1'b1) ? 1 : 0;
        last_addr = vwaddr;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (vwr === 1'b1) begin
                cnt++;
                last_addr = vwaddr;
            end
        end
        check_eq("dbl_count", cnt,       3);
        check_eq("dbl_last",  last_addr, 11'h012);
        check_eq("dbl_busy_end", clr_busy, 0);

        // ---------------- reset mid-fill ----------------
        clr_start = 1'b1; clr_base = 11'h000; clr_len = 12'd2000;
        tick();
        clr_start = 1'b0;
        cnt = 0;
        k   = 0;
        while (cnt < 10 && k < 50) begin
            tick();
            k++;
            if (vwr === 1'b1) cnt++;
        end
        check_eq("rmf_count",  cnt,    10);
        check_eq("rmf_10addr", vwaddr, 11'h009);
        rst = 1'b1;
        tick();
        check_eq("rmf_vwr",  vwr,      0);
        check_eq("rmf_busy", clr_busy, 0);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (vwr === 1'b1) cnt++;
        end
        check_eq("rmf_nowrites", cnt,      0);
        check_eq("rmf_busy2",    clr_busy, 0);
        a_valid = 1'b1; a_addr = 11'h077; a_data = 8'h33;
        #1;
        check_eq("rmf_aready", a_ready, 1);
        tick();
        a_valid = 1'b0;
        check_eq("rmf_a_vwr",    vwr,    1);
        check_eq("rmf_a_vwaddr", vwaddr, 11'h077);
        check_eq("rmf_a_vwdata", vwdata, 8'h33);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
